// File: rtl/gmii_tx_frame_arbiter.sv
// gmii_tx_frame_arbiter
// Frame-level round-robin arbiter for two byte-stream sources sharing one
// GMII transmit port. The block prepends the preamble and SFD, streams the
// granted frame, and holds an inter-frame gap before the next grant.
//
// Build option: define TX_UNDERRUN_ER_EN to flag an underrun on the wire.
// The aborted frame then ends with one dv=1/er=1/data=0x00 cycle. Without the
// macro, an underrun only truncates the frame and gmii_tx_er is tied low.
//
// state | meaning
// IDLE  | no frame in progress, waiting for a source request
// PRE   | sending PREAMBLE_LEN bytes of 0x55
// SFD   | sending the 0xD5 start-of-frame delimiter
// DATA  | passing bytes through from the granted source
// IFG   | IFG_CYCLES clocks of idle line before re-arbitrating
module gmii_tx_frame_arbiter #(
    parameter int PREAMBLE_LEN = 7,
    parameter int IFG_CYCLES   = 12
) (
    input  logic       gmii_tx_clk,
    input  logic       sys_rst,
    input  logic [7:0] s0_data,
    input  logic       s0_valid,
    input  logic       s0_last,
    output logic       s0_ready,
    input  logic [7:0] s1_data,
    input  logic       s1_valid,
    input  logic       s1_last,
    output logic       s1_ready,
    output logic [7:0] gmii_tx_data,
    output logic       gmii_tx_dv,
    output logic       gmii_tx_er,
    output logic       tx_busy,
    output logic       frame_done,
    output logic       tx_underrun
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        SFD  = 3'd2,
        DATA = 3'd3,
        IFG  = 3'd4
    } state_t;

    // Counter is 6 bits so it covers the largest gap (63) and preamble (15).
    localparam logic [5:0] PRE_TC = 6'(PREAMBLE_LEN - 1);
    localparam logic [5:0] IFG_TC = 6'(IFG_CYCLES - 1);

    state_t     state;
    logic [5:0] cnt;
    logic       grant;
    logic       last_grant;
    logic       req_pick;
    logic [7:0] sel_data;
    logic       sel_valid;
    logic       sel_last;
`ifdef TX_UNDERRUN_ER_EN
    logic       er_q;
`endif

    // When both sources request, the one that did not win last time goes next.
    assign req_pick = (s0_valid && s1_valid) ? ~last_grant : s1_valid;

    // Byte-stream view of whichever source currently holds the grant.
    assign sel_data  = grant ? s1_data  : s0_data;
    assign sel_valid = grant ? s1_valid : s0_valid;
    assign sel_last  = grant ? s1_last  : s0_last;

    // Only the granted source is ever accepted, and only while streaming.
    assign s0_ready = (state == DATA) && !grant;
    assign s1_ready = (state == DATA) &&  grant;
    assign tx_busy  = (state != IDLE);

`ifdef TX_UNDERRUN_ER_EN
    assign gmii_tx_er = er_q;
`else
    assign gmii_tx_er = 1'b0;
`endif

    // Frame sequencer: arbitration, preamble/SFD, data pass-through and gap.
    always_ff @(posedge gmii_tx_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state        <= IDLE;
            cnt          <= '0;
            grant        <= 1'b0;
            last_grant   <= 1'b1;
            gmii_tx_data <= '0;
            gmii_tx_dv   <= 1'b0;
            frame_done   <= 1'b0;
            tx_underrun  <= 1'b0;
`ifdef TX_UNDERRUN_ER_EN
            er_q         <= 1'b0;
`endif
        end else begin
            frame_done  <= 1'b0;
            tx_underrun <= 1'b0;
`ifdef TX_UNDERRUN_ER_EN
            er_q        <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    gmii_tx_dv   <= 1'b0;
                    gmii_tx_data <= 8'h00;
                    if (s0_valid || s1_valid) begin
                        grant      <= req_pick;
                        last_grant <= req_pick;
                        cnt        <= '0;
                        state      <= PRE;
                    end
                end
                PRE: begin
                    gmii_tx_dv   <= 1'b1;
                    gmii_tx_data <= 8'h55;
                    if (cnt == PRE_TC) begin
                        cnt   <= '0;
                        state <= SFD;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                SFD: begin
                    gmii_tx_dv   <= 1'b1;
                    gmii_tx_data <= 8'hD5;
                    cnt          <= '0;
                    state        <= DATA;
                end
                DATA: begin
                    cnt <= '0;
                    if (sel_valid) begin
                        gmii_tx_dv   <= 1'b1;
                        gmii_tx_data <= sel_data;
                        if (sel_last) begin
                            frame_done <= 1'b1;
                            state      <= IFG;
                        end
                    end else begin
                        // Source starved mid-frame: abandon it, never resume.
                        tx_underrun  <= 1'b1;
                        gmii_tx_data <= 8'h00;
                        state        <= IFG;
`ifdef TX_UNDERRUN_ER_EN
                        gmii_tx_dv   <= 1'b1;
                        er_q         <= 1'b1;
`else
                        gmii_tx_dv   <= 1'b0;
`endif
                    end
                end
                IFG: begin
                    gmii_tx_dv   <= 1'b0;
                    gmii_tx_data <= 8'h00;
                    if (cnt == IFG_TC) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                default: begin
                    gmii_tx_dv   <= 1'b0;
                    gmii_tx_data <= 8'h00;
                    cnt          <= '0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gmii_tx_frame_arbiter.sv
// Self-checking bench for gmii_tx_frame_arbiter. A second instance with
// IFG_CYCLES=1 covers the minimum-gap back-to-back case.
module tb_gmii_tx_frame_arbiter;

    localparam int TB_PRE = 7;
    localparam int TB_IFG = 12;
    localparam int LOGN   = 4096;

    logic       clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [7:0] s0_data = 8'h00;
    logic       s0_valid = 1'b0;
    logic       s0_last = 1'b0;
    logic       s0_ready;
    logic [7:0] s1_data = 8'h00;
    logic       s1_valid = 1'b0;
    logic       s1_last = 1'b0;
    logic       s1_ready;
    logic [7:0] tx_data;
    logic       tx_dv, tx_er, busy, fdone, urun;

    logic       x_s0_ready, x_s1_ready;
    logic [7:0] x_tx_data;
    logic       x_tx_dv, x_tx_er, x_busy, x_fdone, x_urun;

    always #4 clk = ~clk;

    gmii_tx_frame_arbiter #(.PREAMBLE_LEN(TB_PRE), .IFG_CYCLES(TB_IFG)) dut (
        .gmii_tx_clk (clk),
        .sys_rst     (sys_rst),
        .s0_data     (s0_data),
        .s0_valid    (s0_valid),
        .s0_last     (s0_last),
        .s0_ready    (s0_ready),
        .s1_data     (s1_data),
        .s1_valid    (s1_valid),
        .s1_last     (s1_last),
        .s1_ready    (s1_ready),
        .gmii_tx_data(tx_data),
        .gmii_tx_dv  (tx_dv),
        .gmii_tx_er  (tx_er),
        .tx_busy     (busy),
        .frame_done  (fdone),
        .tx_underrun (urun)
    );

    gmii_tx_frame_arbiter #(.PREAMBLE_LEN(TB_PRE), .IFG_CYCLES(1)) dut_ifg1 (
        .gmii_tx_clk (clk),
        .sys_rst     (sys_rst),
        .s0_data     (s0_data),
        .s0_valid    (s0_valid),
        .s0_last     (s0_last),
        .s0_ready    (x_s0_ready),
        .s1_data     (8'h00),
        .s1_valid    (1'b0),
        .s1_last     (1'b0),
        .s1_ready    (x_s1_ready),
        .gmii_tx_data(x_tx_data),
        .gmii_tx_dv  (x_tx_dv),
        .gmii_tx_er  (x_tx_er),
        .tx_busy     (x_busy),
        .frame_done  (x_fdone),
        .tx_underrun (x_urun)
    );

    int total = 0;
    int bad   = 0;
    bit tgt   = 1'b0;

    // per-cycle output log of the selected instance
    int         ncyc = 0;
    logic       lg_dv   [LOGN];
    logic [7:0] lg_data [LOGN];
    logic       lg_er   [LOGN];
    logic       lg_fd   [LOGN];
    logic       lg_ur   [LOGN];
    logic       lg_busy [LOGN];

    always @(posedge clk) begin
        #1;
        if (ncyc < LOGN) begin
            lg_dv[ncyc]   <= tgt ? x_tx_dv   : tx_dv;
            lg_data[ncyc] <= tgt ? x_tx_data : tx_data;
            lg_er[ncyc]   <= tgt ? x_tx_er   : tx_er;
            lg_fd[ncyc]   <= tgt ? x_fdone   : fdone;
            lg_ur[ncyc]   <= tgt ? x_urun    : urun;
            lg_busy[ncyc] <= tgt ? x_busy    : busy;
        end
        ncyc <= ncyc + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // source models: each entry is {last, data}
    logic [8:0] m0[$];
    logic [8:0] m1[$];
    int i0 = 0, i1 = 0, drop0 = -1;
    bit en0 = 1'b0, en1 = 1'b0;

    task automatic drive();
        s0_valid = en0 && (i0 < m0.size()) && !(drop0 >= 0 && i0 >= drop0);
        s0_data  = (i0 < m0.size()) ? m0[i0][7:0] : 8'h00;
        s0_last  = (i0 < m0.size()) ? m0[i0][8]   : 1'b0;
        s1_valid = en1 && (i1 < m1.size());
        s1_data  = (i1 < m1.size()) ? m1[i1][7:0] : 8'h00;
        s1_last  = (i1 < m1.size()) ? m1[i1][8]   : 1'b0;
    endtask

    task automatic cycle();
        bit a0, a1;
        a0 = s0_valid && (tgt ? x_s0_ready : s0_ready);
        a1 = s1_valid && s1_ready;
        @(posedge clk);
        @(negedge clk);
        if (a0) i0++;
        if (a1) i1++;
        drive();
    endtask

    task automatic run(input int budget, input string nm);
        int n;
        n = 0;
        while ((s0_valid || s1_valid || (tgt ? x_busy : busy)) && n < budget) begin
            cycle();
            n++;
        end
        if (n >= budget) begin
            total++;
            bad++;
            $display("FAIL %s timeout: ran %0d cycles, limit %0d", nm, n, budget);
        end
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sys_rst = 1'b0;
    endtask

    // frame extraction from the log
    int         nfr, n_fd, n_ur, n_er, ur_at, er_at;
    int         fr_start [16];
    int         fr_len   [16];
    logic [7:0] fr_b     [16][64];
    logic [7:0] pl[$];

    task automatic scan(input int from, input int to);
        nfr = 0; n_fd = 0; n_ur = 0; n_er = 0; ur_at = -1; er_at = -1;
        for (int k = 0; k < 16; k++) begin
            fr_start[k] = 0;
            fr_len[k]   = 0;
        end
        for (int c = from; c < to && c < LOGN; c++) begin
            if (lg_dv[c] === 1'b1 && (c == from || lg_dv[c-1] !== 1'b1)) begin
                if (nfr < 16) fr_start[nfr] = c;
                nfr++;
            end
            if (lg_dv[c] === 1'b1 && nfr > 0 && nfr <= 16 && fr_len[nfr-1] < 64) begin
                fr_b[nfr-1][fr_len[nfr-1]] = lg_data[c];
                fr_len[nfr-1]++;
            end
            if (lg_fd[c] === 1'b1) n_fd++;
            if (lg_ur[c] === 1'b1) begin
                n_ur++;
                if (ur_at < 0) ur_at = c;
            end
            if (lg_er[c] === 1'b1) begin
                n_er++;
                if (er_at < 0) er_at = c;
            end
        end
    endtask

    task automatic check_frame(input string nm, input int k);
        int nb, el;
        logic [7:0] e;
        nb = 0;
        el = TB_PRE + 1 + pl.size();
        chk({nm, " len"}, fr_len[k], el);
        for (int j = 0; j < el && j < 64; j++) begin
            if (j < TB_PRE)       e = 8'h55;
            else if (j == TB_PRE) e = 8'hD5;
            else                  e = pl[j-TB_PRE-1];
            if (fr_b[k][j] !== e) nb++;
        end
        chk({nm, " bytes"}, nb, 0);
    endtask

    typedef struct packed {
        logic       s0v;
        logic [7:0] s0d;
        logic       s0l;
        logic       r0;
        logic       dv;
        logic [7:0] d;
        logic       fd;
    } vec_t;

    vec_t tv[14];

    function automatic vec_t mk(input logic s0v, input logic [7:0] s0d, input logic s0l,
                                input logic r0, input logic dv, input logic [7:0] d,
                                input logic fd);
        vec_t v;
        v.s0v = s0v; v.s0d = s0d; v.s0l = s0l; v.r0 = r0;
        v.dv = dv; v.d = d; v.fd = fd;
        return v;
    endfunction

    initial begin
        int mark, n, bc;

        // single 4-byte frame from s0, cycle by cycle
        tv[0] = mk(1, 8'h11, 0, 0, 0, 8'h00, 0);
        for (int k = 1; k <= 7; k++) tv[k] = mk(1, 8'h11, 0, 0, 1, 8'h55, 0);
        tv[8]  = mk(1, 8'h11, 0, 0, 1, 8'hD5, 0);
        tv[9]  = mk(1, 8'h11, 0, 1, 1, 8'h11, 0);
        tv[10] = mk(1, 8'h22, 0, 1, 1, 8'h22, 0);
        tv[11] = mk(1, 8'h33, 0, 1, 1, 8'h33, 0);
        tv[12] = mk(1, 8'h44, 1, 1, 1, 8'h44, 1);
        tv[13] = mk(0, 8'h00, 0, 0, 0, 8'h00, 0);

        // reset state
        sys_rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst dv", tx_dv, 0);
        chk("rst data", tx_data, 0);
        chk("rst er", tx_er, 0);
        chk("rst busy", busy, 0);
        chk("rst frame_done", fdone, 0);
        chk("rst underrun", urun, 0);
        chk("rst s0_ready", s0_ready, 0);
        @(negedge clk);
        sys_rst = 1'b0;

        // test 1: table-driven single frame
        for (int k = 0; k < 14; k++) begin
            s0_valid = tv[k].s0v;
            s0_data  = tv[k].s0d;
            s0_last  = tv[k].s0l;
            s1_valid = 1'b0;
            #1;
            chk($sformatf("t1[%0d] s0_ready", k), s0_ready, tv[k].r0);
            chk($sformatf("t1[%0d] s1_ready", k), s1_ready, 0);
            @(posedge clk);
            #1;
            chk($sformatf("t1[%0d] dv", k), tx_dv, tv[k].dv);
            chk($sformatf("t1[%0d] data", k), tx_data, tv[k].d);
            chk($sformatf("t1[%0d] frame_done", k), fdone, tv[k].fd);
            chk($sformatf("t1[%0d] busy", k), busy, 1);
            @(negedge clk);
        end
        repeat (10) @(posedge clk);
        #1;
        chk("t1 ifg busy", busy, 1);
        @(posedge clk);
        #1;
        chk("t1 ifg end", busy, 0);
        @(negedge clk);

        // test 2: simultaneous requests after reset, s0 first
        do_reset();
        m0 = {9'h0A1, 9'h0A2, 9'h1A3};
        m1 = {9'h0B1, 9'h0B2, 9'h1B3};
        i0 = 0; i1 = 0; en0 = 1; en1 = 1; drop0 = -1;
        drive();
        mark = ncyc;
        run(300, "t2");
        scan(mark, ncyc);
        chk("t2 frames", nfr, 2);
        pl = {8'hA1, 8'hA2, 8'hA3}; check_frame("t2 f0", 0);
        pl = {8'hB1, 8'hB2, 8'hB3}; check_frame("t2 f1", 1);
        chk("t2 gap", fr_start[1] - (fr_start[0] + fr_len[0]), TB_IFG + 1);
        chk("t2 frame_done", n_fd, 2);

        // test 3: round robin over four frames, s1 served last
        m0 = {9'h0C0, 9'h1C1, 9'h0C4, 9'h1C5};
        m1 = {9'h0C2, 9'h1C3, 9'h0C6, 9'h1C7};
        i0 = 0; i1 = 0;
        drive();
        mark = ncyc;
        run(500, "t3");
        scan(mark, ncyc);
        chk("t3 frames", nfr, 4);
        pl = {8'hC0, 8'hC1}; check_frame("t3 f0", 0);
        pl = {8'hC2, 8'hC3}; check_frame("t3 f1", 1);
        pl = {8'hC4, 8'hC5}; check_frame("t3 f2", 2);
        pl = {8'hC6, 8'hC7}; check_frame("t3 f3", 3);
        chk("t3 gap", fr_start[3] - (fr_start[2] + fr_len[2]), TB_IFG + 1);

        // test 4: s0 stops after byte 2 of 6
        en1 = 0; m1 = {};
        m0 = {9'h061, 9'h062, 9'h063, 9'h064, 9'h065, 9'h166};
        i0 = 0; i1 = 0; drop0 = 2;
        drive();
        mark = ncyc;
        run(300, "t4");
        scan(mark, ncyc);
        chk("t4 frames", nfr, 1);
        chk("t4 frame_done", n_fd, 0);
        chk("t4 underrun count", n_ur, 1);
        chk("t4 underrun pos", ur_at - fr_start[0], TB_PRE + 3);
`ifdef TX_UNDERRUN_ER_EN
        pl = {8'h61, 8'h62, 8'h00}; check_frame("t4 f0", 0);
        chk("t4 er count", n_er, 1);
        chk("t4 er pos", er_at, ur_at);
`else
        pl = {8'h61, 8'h62}; check_frame("t4 f0", 0);
        chk("t4 er count", n_er, 0);
`endif
        chk("t4 dv after", (ur_at >= 0) ? lg_dv[ur_at+1] : 1'bx, 0);
        bc = 0;
        for (int c = ur_at; c >= 0 && c < ncyc && lg_busy[c] === 1'b1; c++) bc++;
        chk("t4 ifg length", bc, TB_IFG);
        m0 = {}; i0 = 0; drop0 = -1; en0 = 0;
        drive();

        // test 5: async reset mid-frame, then s1 alone gets the grant
        m0 = {9'h071, 9'h072, 9'h073, 9'h074, 9'h075, 9'h176};
        i0 = 0; en0 = 1;
        drive();
        n = 0;
        while (!s0_ready && n < 40) begin
            cycle();
            n++;
        end
        chk("t5 reached data", s0_ready, 1);
        cycle();
        cycle();
        chk("t5 dv before reset", tx_dv, 1);
        #2;
        sys_rst = 1'b1;
        #1;
        chk("t5 rst dv", tx_dv, 0);
        chk("t5 rst data", tx_data, 0);
        chk("t5 rst er", tx_er, 0);
        chk("t5 rst busy", busy, 0);
        en0 = 0; m0 = {}; i0 = 0;
        m1 = {9'h0D1, 9'h0D2, 9'h1D3};
        i1 = 0; en1 = 1;
        drive();
        @(posedge clk);
        @(negedge clk);
        sys_rst = 1'b0;
        mark = ncyc;
        run(300, "t5");
        scan(mark, ncyc);
        chk("t5 frames", nfr, 1);
        pl = {8'hD1, 8'hD2, 8'hD3}; check_frame("t5 f0", 0);
        en1 = 0; m1 = {}; i1 = 0;
        drive();

        // test 6: IFG_CYCLES=1 instance, back-to-back s0 frames
        tgt = 1'b1;
        do_reset();
        m0 = {9'h0E1, 9'h1E2, 9'h0E3, 9'h0E4, 9'h1E5, 9'h1E6};
        i0 = 0; en0 = 1;
        drive();
        mark = ncyc;
        run(300, "t6");
        scan(mark, ncyc);
        chk("t6 frames", nfr, 3);
        pl = {8'hE1, 8'hE2};        check_frame("t6 f0", 0);
        pl = {8'hE3, 8'hE4, 8'hE5}; check_frame("t6 f1", 1);
        pl = {8'hE6};               check_frame("t6 f2", 2);
        chk("t6 gap0", fr_start[1] - (fr_start[0] + fr_len[0]), 2);
        chk("t6 gap1", fr_start[2] - (fr_start[1] + fr_len[1]), 2);
        chk("t6 frame_done", n_fd, 3);
        chk("t6 s1_ready", x_s1_ready, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
